div_ctrl: RTL and testbench
===========================

// Module: div_ctrl
// PURPOSE
//   Control FSM for the shift-subtract (restoring) divider datapath.
//   Sequences the datapath register's INIT/SH/LDA strobes for WIDTH iterations.
//   Decides each quotient bit from the subtractor's A>=B flag.
//   Provides the start/busy/done handshake to the host and flags divide-by-zero.
//   Updates on posedge clk; the datapath acts on negedge clk, so strobes are stable when sampled.
// PARAMETERS
//   WIDTH   16  operand/quotient width = number of iterations
//   CNT_W   5   iteration counter width, must satisfy 2**CNT_W > WIDTH
// PORTS
//   clk          in   1      system clock, rising edge
//   rst          in   1      synchronous, active-high reset
//   start        in   1      request a division; sampled only in IDLE
//   a_ge_b       in   1      subtractor flag: partial remainder A >= divisor
//   dv_zero      in   1      divisor == 0, sampled in INIT
//   INIT         out  1      datapath clear/load strobe
//   SH           out  1      datapath shift strobe
//   LDA          out  1      datapath load A <= A-divisor, quotient bit <= 1
//   busy         out  1      high in INIT, SHIFT, CHECK and LOAD
//   done         out  1      one-cycle pulse, result valid from this cycle
//   div_by_zero  out  1      held with done, cleared on next INIT
// BEHAVIOUR
//   Reset values: state=IDLE, cnt=0, and every output =0 (including div_by_zero).
//   rst has priority over every other input, including mid-operation.
//   All outputs are registered/Moore: a pure function of state, except div_by_zero, which is a flop.
//   States and outputs:
//     IDLE   outputs none.  start=1 -> INIT; otherwise stay.
//     INIT   INIT=1 busy=1; cnt<=WIDTH; div_by_zero<=dv_zero.
//            dv_zero=1 -> DONE; otherwise -> SHIFT.
//     SHIFT  SH=1 busy=1; cnt<=cnt-1 -> CHECK.
//     CHECK  busy=1; a_ge_b is evaluated on the shifted A.
//            a_ge_b=1 -> LOAD.
//            a_ge_b=0 and cnt==0 -> DONE.
//            a_ge_b=0 and cnt!=0 -> SHIFT.
//     LOAD   LDA=1 busy=1.  cnt==0 -> DONE; otherwise -> SHIFT.
//     DONE   done=1 -> IDLE.
//   Exactly one of INIT/SH/LDA is high per cycle, or none.
//   Latency, normal divide:
//     busy is high for 1 + 2*WIDTH + popcount(Q) cycles; done follows in the next cycle.
//     Q is the resulting quotient.
//   Latency, divide-by-zero:
//     busy is high for 1 cycle (INIT), then done.
//     No SH or LDA is issued, so the datapath quotient reads 0.
//   start is a level signal:
//     Ignored while busy or in DONE.
//     If still high when IDLE is re-entered, a new division starts.
//   cnt never wraps. The decrement occurs only in SHIFT, at most WIDTH times per operation.
//   Unused/illegal state encodings -> IDLE on the next clock.
// STRUCTURE
//   Shared package div_pkg:
//     state encoding localparams S_IDLE..S_DONE (3-bit).
//     DIV_WIDTH default 16.
//   Sub-module div_iter_cnt: loadable down-counter.
//     Ports: clk, rst, ld, dec, ld_val[CNT_W], zero, cnt.
//   FSM next-state logic and output decode live in div_ctrl itself.
// TESTING
//   Bench pairs div_ctrl with the datapath register and a subtractor model; WIDTH=16.
//   1. 100/7 -> Q=14, R=2; busy high 36 cycles; exactly 3 LDA pulses and 16 SH pulses; done pulse 1 cycle.
//   2. 0xFFFF/1 -> Q=0xFFFF; busy 49 cycles; 16 LDA pulses.
//   3. 0/5 -> Q=0; busy 33 cycles; zero LDA pulses.
//   4. x/0 (dv_zero=1) -> INIT, then done with div_by_zero=1 after 1 busy cycle; no SH or LDA; next valid op clears the flag.
//   5. rst=1 in cycle 10 of 100/7 -> next cycle IDLE with all outputs 0; fresh start then completes correctly.
//   6. start held high through done -> second division begins in the cycle after DONE; start pulses during busy have no effect.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the restoring-divider controller: state encodings and default sizes.
package div_pkg;

    localparam int DIV_WIDTH = 16;
    localparam int DIV_CNT_W = 5;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_INIT  = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_CHECK = 3'd3;
    localparam logic [2:0] S_LOAD  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE  = S_IDLE,
        ST_INIT  = S_INIT,
        ST_SHIFT = S_SHIFT,
        ST_CHECK = S_CHECK,
        ST_LOAD  = S_LOAD,
        ST_DONE  = S_DONE
    } state_t;

endpackage

// File: rtl/div_iter_cnt.sv
// Loadable iteration down-counter; load wins over decrement, zero flags terminal count.
module div_iter_cnt
    import div_pkg::*;
#(
    parameter int CNT_W = DIV_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic             dec,
    input  logic [CNT_W-1:0] ld_val,
    output logic             zero,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (ld) begin
            cnt_d = ld_val;
        end else if (dec) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign zero = (cnt_q == '0);

endmodule

// File: rtl/div_ctrl.sv
// Control FSM for the shift-subtract divider: sequences INIT/SH/LDA strobes and the start/busy/done handshake.
//   state | meaning
//   IDLE  | waiting for start
//   INIT  | clear/load datapath, load iteration count, capture divide-by-zero
//   SHIFT | shift partial remainder/quotient left, count one iteration
//   CHECK | compare shifted remainder against divisor
//   LOAD  | subtract divisor, set quotient bit
//   DONE  | one-cycle completion pulse
module div_ctrl
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = DIV_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic a_ge_b,
    input  logic dv_zero,
    output logic INIT,
    output logic SH,
    output logic LDA,
    output logic busy,
    output logic done,
    output logic div_by_zero
);

    state_t           state_q, state_d;
    logic             dbz_q;
    logic             cnt_ld, cnt_dec, cnt_zero;
    logic [CNT_W-1:0] cnt;

    // The non-zero guard keeps the iteration count from ever wrapping.
    assign cnt_ld  = (state_q == ST_INIT);
    assign cnt_dec = (state_q == ST_SHIFT) && (cnt != '0);

    div_iter_cnt #(
        .CNT_W (CNT_W)
    ) u_iter_cnt (
        .clk    (clk),
        .rst    (rst),
        .ld     (cnt_ld),
        .dec    (cnt_dec),
        .ld_val (CNT_W'(WIDTH)),
        .zero   (cnt_zero),
        .cnt    (cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_INIT) begin
                dbz_q <= dv_zero;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        INIT    = 1'b0;
        SH      = 1'b0;
        LDA     = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_INIT;
            end
            ST_INIT: begin
                INIT    = 1'b1;
                busy    = 1'b1;
                state_d = dv_zero ? ST_DONE : ST_SHIFT;
            end
            ST_SHIFT: begin
                SH      = 1'b1;
                busy    = 1'b1;
                state_d = ST_CHECK;
            end
            ST_CHECK: begin
                busy = 1'b1;
                if (a_ge_b)        state_d = ST_LOAD;
                else if (cnt_zero) state_d = ST_DONE;
                else               state_d = ST_SHIFT;
            end
            ST_LOAD: begin
                LDA     = 1'b1;
                busy    = 1'b1;
                state_d = cnt_zero ? ST_DONE : ST_SHIFT;
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench: div_ctrl driving a negedge restoring-divider datapath model, WIDTH=16.
module tb_div_ctrl;

    logic clk = 1'b0;
    logic rst, start, a_ge_b, dv_zero;
    logic INIT, SH, LDA, busy, done, div_by_zero;

    logic [15:0] dividend_in = '0;
    logic [15:0] divisor_in  = '0;

    logic [16:0] dp_a = '0;
    logic [15:0] dp_d = '0;
    logic [15:0] dp_q = '0;
    logic [15:0] dp_b = '0;

    int mon_busy = 0, mon_sh = 0, mon_lda = 0, mon_done = 0, mon_multi = 0;
    int s_busy, s_sh, s_lda, s_done;
    int n_tests = 0, n_fail = 0;

    always #5 clk = ~clk;

    div_ctrl #(.WIDTH(16), .CNT_W(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .a_ge_b      (a_ge_b),
        .dv_zero     (dv_zero),
        .INIT        (INIT),
        .SH          (SH),
        .LDA         (LDA),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    assign a_ge_b  = (dp_a >= {1'b0, dp_b});
    assign dv_zero = (divisor_in == 16'd0);

    always @(negedge clk) begin
        if (INIT) begin
            dp_a <= '0;
            dp_d <= dividend_in;
            dp_q <= '0;
            dp_b <= divisor_in;
        end else if (SH) begin
            {dp_a, dp_d} <= {dp_a[15:0], dp_d, 1'b0};
            dp_q         <= {dp_q[14:0], 1'b0};
        end else if (LDA) begin
            dp_a    <= dp_a - {1'b0, dp_b};
            dp_q[0] <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (busy) mon_busy++;
        if (SH)   mon_sh++;
        if (LDA)  mon_lda++;
        if (done) mon_done++;
        if ((int'(INIT) + int'(SH) + int'(LDA)) > 1) mon_multi++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic snap();
        s_busy = mon_busy;
        s_sh   = mon_sh;
        s_lda  = mon_lda;
        s_done = mon_done;
    endtask

    task automatic launch(input logic [15:0] dd, input logic [15:0] dv);
        dividend_in = dd;
        divisor_in  = dv;
        start       = 1'b1;
        snap();
        tick();
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 200; i++) begin
            if (done) break;
            tick();
        end
        check({tag, "_done_seen"}, 32'(done), 32'd1);
    endtask

    task automatic check_result(input string tag, input logic [15:0] q, input logic [15:0] r,
                                input int nbusy, input int nsh, input int nlda, input logic dbz);
        check({tag, "_q"},    32'(dp_q), 32'(q));
        check({tag, "_r"},    32'(dp_a[15:0]), 32'(r));
        check({tag, "_busy"}, 32'(mon_busy - s_busy), 32'(nbusy));
        check({tag, "_sh"},   32'(mon_sh - s_sh), 32'(nsh));
        check({tag, "_lda"},  32'(mon_lda - s_lda), 32'(nlda));
        check({tag, "_dbz"},  32'(div_by_zero), 32'(dbz));
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        repeat (3) tick();
        check("reset_outs", 32'({INIT, SH, LDA, busy, done, div_by_zero}), 32'd0);
        rst = 1'b0;
        tick();
        check("idle_no_start", 32'(busy), 32'd0);

        // 1: 100/7
        launch(16'd100, 16'd7);
        start = 1'b0;
        check("t1_init_first", 32'({INIT, busy}), 32'b11);
        wait_done("t1");
        check_result("t1", 16'd14, 16'd2, 36, 16, 3, 1'b0);
        tick();
        check("t1_done_pulse", 32'({done, busy}), 32'd0);
        check("t1_done_cnt", 32'(mon_done - s_done), 32'd1);

        // 2: 0xFFFF/1
        launch(16'hFFFF, 16'd1);
        start = 1'b0;
        wait_done("t2");
        check_result("t2", 16'hFFFF, 16'd0, 49, 16, 16, 1'b0);
        tick();

        // 3: 0/5
        launch(16'd0, 16'd5);
        start = 1'b0;
        wait_done("t3");
        check_result("t3", 16'd0, 16'd0, 33, 16, 0, 1'b0);
        tick();

        // 4: divide by zero, flag held into IDLE, cleared by next valid op
        launch(16'd1234, 16'd0);
        start = 1'b0;
        check("t4_init", 32'(INIT), 32'd1);
        tick();
        check("t4_done_next", 32'(done), 32'd1);
        check_result("t4", 16'd0, 16'd0, 1, 0, 0, 1'b1);
        tick();
        check("t4_dbz_held", 32'({div_by_zero, busy}), 32'b10);
        launch(16'd9, 16'd3);
        start = 1'b0;
        tick();
        check("t4_dbz_cleared", 32'(div_by_zero), 32'd0);
        wait_done("t4b");
        check_result("t4b", 16'd3, 16'd0, 35, 16, 2, 1'b0);
        tick();

        // 5: reset in cycle 10 of 100/7, then a clean rerun
        launch(16'd100, 16'd7);
        start = 1'b0;
        repeat (9) tick();
        check("t5_busy_before_rst", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        check("t5_rst_outs", 32'({INIT, SH, LDA, busy, done, div_by_zero}), 32'd0);
        rst = 1'b0;
        tick();
        check("t5_stays_idle", 32'(busy), 32'd0);
        launch(16'd100, 16'd7);
        start = 1'b0;
        wait_done("t5");
        check_result("t5", 16'd14, 16'd2, 36, 16, 3, 1'b0);
        tick();

        // 6: start held through done restarts; start pulses mid-op are ignored
        launch(16'd1000, 16'd33);
        wait_done("t6a");
        check_result("t6a", 16'd30, 16'd10, 37, 16, 4, 1'b0);
        tick();
        check("t6_idle_after_done", 32'({busy, done, INIT}), 32'd0);
        snap();
        tick();
        check("t6_restart_init", 32'({INIT, busy}), 32'b11);
        start = 1'b0;
        repeat (5) tick();
        start = 1'b1;
        repeat (3) tick();
        start = 1'b0;
        wait_done("t6b");
        check_result("t6b", 16'd30, 16'd10, 37, 16, 4, 1'b0);
        tick();
        tick();
        check("t6_no_extra_start", 32'(busy), 32'd0);

        check("strobe_onehot", 32'(mon_multi), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
